// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings: instruction codes, status codes and the hazard-control FSM states.
package y86_pkg;

   localparam logic [3:0] ICODE_HALT   = 4'h0;
   localparam logic [3:0] ICODE_NOP    = 4'h1;
   localparam logic [3:0] ICODE_RRMOVQ = 4'h2;
   localparam logic [3:0] ICODE_IRMOVQ = 4'h3;
   localparam logic [3:0] ICODE_RMMOVQ = 4'h4;
   localparam logic [3:0] ICODE_MRMOVQ = 4'h5;
   localparam logic [3:0] ICODE_OPQ    = 4'h6;
   localparam logic [3:0] ICODE_JXX    = 4'h7;
   localparam logic [3:0] ICODE_CALL   = 4'h8;
   localparam logic [3:0] ICODE_RET    = 4'h9;
   localparam logic [3:0] ICODE_PUSHQ  = 4'hA;
   localparam logic [3:0] ICODE_POPQ   = 4'hB;

   localparam logic [1:0] STAT_AOK = 2'b00;
   localparam logic [1:0] STAT_HLT = 2'b01;
   localparam logic [1:0] STAT_ADR = 2'b10;
   localparam logic [1:0] STAT_INS = 2'b11;

   localparam logic [3:0] RNONE = 4'hF;

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_RET_WAIT = 2'd1,
      ST_HALT     = 2'd2
   } pipe_state_e;

endpackage

// File: rtl/pipe_ret_timer.sv
// Down-counter that measures the remaining RET_WAIT cycles; busy while cycles remain.
module pipe_ret_timer #(
   parameter int unsigned RET_STALL_CYC = 3
) (
   input  logic clk,
   input  logic reset,
   input  logic start,
   input  logic abort,
   output logic busy
);

   logic [2:0] cnt;

   // Loaded with RET_STALL_CYC-2: the RUN cycle and the final zero-count cycle make up the rest.
   always_ff @(posedge clk) begin
      if (reset || abort)
         cnt <= '0;
      else if (start)
         cnt <= 3'(RET_STALL_CYC - 2);
      else if (cnt != '0)
         cnt <= cnt - 3'd1;
   end

   assign busy = (cnt != '0);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Y86-64 PIPE stall/bubble control with RUN / RET_WAIT / HALT sequencing.
// Optional perf counters are enabled by defining PIPE_PERF_CNT_EN.
module pipe_hazard_ctrl
   import y86_pkg::*;
#(
   parameter int unsigned RET_STALL_CYC = 3
`ifdef PIPE_PERF_CNT_EN
   , parameter int unsigned CNT_W = 32
`endif
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] D_icode,
   input  logic [3:0] d_srcA,
   input  logic [3:0] d_srcB,
   input  logic [3:0] E_icode,
   input  logic [3:0] E_dstM,
   input  logic       e_cnd,
   input  logic [1:0] m_stat,
   input  logic [1:0] W_stat,
   output logic       F_stall,
   output logic       D_stall,
   output logic       D_bubble,
   output logic       E_bubble,
   output logic       M_bubble,
   output logic       W_stall,
   output logic       set_cc,
   output logic       halted
`ifdef PIPE_PERF_CNT_EN
   , output logic [CNT_W-1:0] stall_cnt
   , output logic [CNT_W-1:0] mispred_cnt
   , output logic [CNT_W-1:0] ret_cnt_o
`endif
);

   pipe_state_e state, state_nxt;
   logic load_use, mispred, exc, ret_in_d;
   logic ret_start, ret_abort, ret_busy;

   assign load_use = ((E_icode == ICODE_MRMOVQ) || (E_icode == ICODE_POPQ)) &&
                     (E_dstM != RNONE) && ((E_dstM == d_srcA) || (E_dstM == d_srcB));
   assign mispred  = (E_icode == ICODE_JXX) && !e_cnd;
   assign exc      = (m_stat != STAT_AOK) || (W_stat != STAT_AOK);
   assign ret_in_d = (D_icode == ICODE_RET);

   pipe_ret_timer #(.RET_STALL_CYC(RET_STALL_CYC)) u_ret_timer (
      .clk   (clk),
      .reset (reset),
      .start (ret_start),
      .abort (ret_abort),
      .busy  (ret_busy)
   );

   always_ff @(posedge clk) begin
      if (reset)
         state <= ST_RUN;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      ret_start = 1'b0;
      ret_abort = 1'b0;
      case (state)
         ST_RUN: begin
            if (!mispred && !load_use && ret_in_d) begin
               state_nxt = ST_RET_WAIT;
               ret_start = 1'b1;
            end
         end
         ST_RET_WAIT: begin
            if (mispred) begin
               state_nxt = ST_RUN;
               ret_abort = 1'b1;
            end else if (!ret_busy) begin
               state_nxt = ST_RUN;
            end
         end
         ST_HALT: state_nxt = ST_HALT;
         default: state_nxt = ST_RUN;
      endcase
      if (W_stat != STAT_AOK)
         state_nxt = ST_HALT;
   end

   always_comb begin
      F_stall  = 1'b0;
      D_stall  = 1'b0;
      D_bubble = 1'b0;
      E_bubble = 1'b0;
      M_bubble = 1'b0;
      W_stall  = 1'b0;
      set_cc   = 1'b0;
      halted   = 1'b0;
      if (reset) begin
         D_bubble = 1'b1;
         E_bubble = 1'b1;
         M_bubble = 1'b1;
      end else begin
         case (state)
            ST_RUN: begin
               if (mispred) begin
                  D_bubble = 1'b1;
                  E_bubble = 1'b1;
               end else if (load_use) begin
                  F_stall  = 1'b1;
                  D_stall  = 1'b1;
                  E_bubble = 1'b1;
               end else if (ret_in_d) begin
                  F_stall  = 1'b1;
                  D_bubble = 1'b1;
               end
            end
            ST_RET_WAIT: begin
               // An aborting mispredict must fetch the corrected PC, so F is released.
               if (mispred) begin
                  D_bubble = 1'b1;
                  E_bubble = 1'b1;
               end else begin
                  F_stall  = 1'b1;
                  D_bubble = 1'b1;
               end
            end
            ST_HALT: begin
               F_stall  = 1'b1;
               D_stall  = 1'b1;
               W_stall  = 1'b1;
               E_bubble = 1'b1;
               M_bubble = 1'b1;
               halted   = 1'b1;
            end
            default: ;
         endcase
         if (exc)
            M_bubble = 1'b1;
         set_cc = (E_icode == ICODE_OPQ) && !exc && (state != ST_HALT);
      end
   end

`ifdef PIPE_PERF_CNT_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cnt   <= '0;
         mispred_cnt <= '0;
         ret_cnt_o   <= '0;
      end else if (state != ST_HALT) begin
         if (F_stall && (stall_cnt != '1))
            stall_cnt <= stall_cnt + 1'b1;
         if (mispred && (mispred_cnt != '1))
            mispred_cnt <= mispred_cnt + 1'b1;
         if ((state == ST_RUN) && (state_nxt == ST_RET_WAIT) && (ret_cnt_o != '1))
            ret_cnt_o <= ret_cnt_o + 1'b1;
      end
   end
`endif

   a_d_stall_bubble_excl: assert property (@(posedge clk) disable iff (reset) !(D_stall && D_bubble));

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed-vector bench for pipe_hazard_ctrl; strobes packed as {F_stall,D_stall,D_bubble,E_bubble,M_bubble,W_stall,set_cc,halted}.
module tb_pipe_hazard_ctrl;
   import y86_pkg::*;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] D_icode, d_srcA, d_srcB, E_icode, E_dstM;
   logic       e_cnd;
   logic [1:0] m_stat, W_stat;
   logic       F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc, halted;
`ifdef PIPE_PERF_CNT_EN
   logic [31:0] stall_cnt, mispred_cnt, ret_cnt_o;
`endif

   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;

   always #5 clk = ~clk;

   pipe_hazard_ctrl #(.RET_STALL_CYC(3)) dut (
      .clk      (clk),
      .reset    (reset),
      .D_icode  (D_icode),
      .d_srcA   (d_srcA),
      .d_srcB   (d_srcB),
      .E_icode  (E_icode),
      .E_dstM   (E_dstM),
      .e_cnd    (e_cnd),
      .m_stat   (m_stat),
      .W_stat   (W_stat),
      .F_stall  (F_stall),
      .D_stall  (D_stall),
      .D_bubble (D_bubble),
      .E_bubble (E_bubble),
      .M_bubble (M_bubble),
      .W_stall  (W_stall),
      .set_cc   (set_cc),
      .halted   (halted)
`ifdef PIPE_PERF_CNT_EN
      , .stall_cnt   (stall_cnt)
      , .mispred_cnt (mispred_cnt)
      , .ret_cnt_o   (ret_cnt_o)
`endif
   );

   wire [7:0] strobes = {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc, halted};

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp)
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      else
         n_pass++;
   endtask

   task automatic idle();
      D_icode = ICODE_NOP;
      d_srcA  = RNONE;
      d_srcB  = RNONE;
      E_icode = ICODE_NOP;
      E_dstM  = RNONE;
      e_cnd   = 1'b1;
      m_stat  = STAT_AOK;
      W_stat  = STAT_AOK;
   endtask

   // Advance to the next low phase; inputs are driven there and outputs checked 1ns later.
   task automatic next_cycle();
      @(negedge clk);
   endtask

   initial begin
      reset = 1'b1;
      idle();

      // Reset held two cycles: D/E/M bubbles only
      next_cycle(); #1 check("rst_c1", strobes, 8'b0011_1000);
      next_cycle(); #1 check("rst_c2", strobes, 8'b0011_1000);
      next_cycle(); reset = 1'b0; #1 check("idle", strobes, 8'b0000_0000);

      // Load-use via srcA, then via srcB, then dstM = none
      next_cycle(); E_icode = ICODE_MRMOVQ; E_dstM = 4'h3; d_srcA = 4'h3;
      #1 check("ld_use_a", strobes, 8'b1101_0000);
      next_cycle(); idle(); #1 check("ld_use_gone", strobes, 8'b0000_0000);
      next_cycle(); E_icode = ICODE_POPQ; E_dstM = 4'h4; d_srcB = 4'h4;
      #1 check("ld_use_b", strobes, 8'b1101_0000);
      next_cycle(); idle(); E_icode = ICODE_MRMOVQ; E_dstM = RNONE;
      #1 check("ld_use_none", strobes, 8'b0000_0000);

      // ret: F stalled and D bubbled for exactly 3 cycles
      next_cycle(); idle(); D_icode = ICODE_RET; #1 check("ret_c1", strobes, 8'b1010_0000);
      next_cycle(); idle(); #1 check("ret_c2", strobes, 8'b1010_0000);
      next_cycle(); #1 check("ret_c3", strobes, 8'b1010_0000);
      next_cycle(); #1 check("ret_done", strobes, 8'b0000_0000);

      // Mispredict overrides a ret in D; taken jump does nothing
      next_cycle(); D_icode = ICODE_RET; E_icode = ICODE_JXX; e_cnd = 1'b0;
      #1 check("mispred_over_ret", strobes, 8'b0011_0000);
      next_cycle(); idle(); #1 check("no_ret_wait", strobes, 8'b0000_0000);
      next_cycle(); E_icode = ICODE_JXX; e_cnd = 1'b1; #1 check("jxx_taken", strobes, 8'b0000_0000);

      // Mispredict in the 2nd stall cycle aborts RET_WAIT
      next_cycle(); idle(); D_icode = ICODE_RET; #1 check("ret2_c1", strobes, 8'b1010_0000);
      next_cycle(); idle(); E_icode = ICODE_JXX; e_cnd = 1'b0;
      #1 check("abort_db", {31'd0, D_bubble}, 32'd1);
      check("abort_eb", {31'd0, E_bubble}, 32'd1);
      next_cycle(); idle(); #1 check("abort_run", strobes, 8'b0000_0000);

      // Exception masks set_cc and bubbles M, then W_stat error halts
      next_cycle(); E_icode = ICODE_OPQ; #1 check("set_cc", strobes, 8'b0000_0010);
      next_cycle(); m_stat = STAT_ADR; #1 check("exc_m", strobes, 8'b0000_1000);
      next_cycle(); idle(); W_stat = STAT_ADR; #1 check("exc_w", strobes, 8'b0000_1000);
      next_cycle(); idle(); #1 check("halt_c1", strobes, 8'b1101_1101);
      next_cycle(); E_icode = ICODE_OPQ; D_icode = ICODE_RET; #1 check("halt_sticky", strobes, 8'b1101_1101);
      next_cycle(); idle(); #1 check("halt_sticky2", strobes, 8'b1101_1101);
      next_cycle(); reset = 1'b1; #1 check("rst_from_halt", strobes, 8'b0011_1000);
      next_cycle(); reset = 1'b0; #1 check("run_after_halt", strobes, 8'b0000_0000);

`ifdef PIPE_PERF_CNT_EN
      check("cnt_clr_stall", stall_cnt, 32'd0);
      next_cycle(); D_icode = ICODE_RET;
      next_cycle(); idle();
      next_cycle();
      next_cycle(); E_icode = ICODE_JXX; e_cnd = 1'b0;
      next_cycle(); idle(); #1
      check("cnt_stall", stall_cnt, 32'd3);
      check("cnt_mispred", mispred_cnt, 32'd1);
      check("cnt_ret", ret_cnt_o, 32'd1);
`endif

      next_cycle();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
